nrzi_tx_ctrl: RTL and testbench

Transmit sequencer for the NRZI serial line. It accepts parallel words over a valid/ready handshake, frames each word with a sync preamble, and shifts it out MSB-first through a registered NRZI encode stage. It then enforces an inter-frame gap before accepting the next word. It sits between the word-level producer and the single-bit line driver.

---
 rtl/nrzi_pkg.sv | 21 ++
 rtl/nrzi_enc_stage.sv | 35 +++
 rtl/nrzi_tx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_nrzi_tx_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// Shared types and constants for the NRZI transmit path.
// Holds the sequencer state encoding and line-level constants.
package nrzi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        GAP
    } state_e;

    localparam int STUFF_RUN = 6;
    localparam logic LINE_IDLE = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nrzi_enc_stage.sv
// Registered one-bit NRZI encoder: toggles the line on an enabled raw 0.
// The line rests at LINE_IDLE out of reset and holds while disabled.
module nrzi_enc_stage
    import nrzi_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic raw_bit,
    output logic line
);

    logic line_q;
    logic line_d;

    // Next line level: a raw 0 flips the line, a raw 1 holds it.
    always_comb begin
        line_d = line_q;
        if (enable) begin
            line_d = line_q ^ ~raw_bit;
        end
    end

    // Line register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_q <= LINE_IDLE;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/nrzi_tx_ctrl.sv
// NRZI transmit sequencer: preamble, MSB-first data, inter-frame gap.
// Define NRZI_TX_STUFF_EN to insert a raw 0 after six raw 1s in DATA.
module nrzi_tx_ctrl
    import nrzi_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SYNC_LEN = 4,
    parameter int GAP_LEN  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_line,
    output logic             tx_active,
    output logic             frame_done
);

    localparam int CW = $clog2(max3(WIDTH, SYNC_LEN, GAP_LEN) + 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DATA_END  = CW'(WIDTH);
    localparam logic [CW-1:0] GAP_LAST  =
        CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             raw_bit;
    logic             last_bit;
    logic             stuff_c;
    logic             owe;

`ifdef NRZI_TX_STUFF_EN
    localparam int RW = $clog2(STUFF_RUN + 1);
    localparam logic [RW-1:0] RUN_FULL = RW'(STUFF_RUN);
    localparam logic [RW-1:0] RUN_PRE  = RW'(STUFF_RUN - 1);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;

    assign stuff_c = (state_q == DATA) && (run_q == RUN_FULL);
    assign owe     = shift_q[WIDTH-1] && (run_q == RUN_PRE);

    // Run of consecutive raw 1s; preamble and stuffed 0s clear it.
    always_comb begin
        run_d = run_q;
        if (state_q == SYNC) begin
            run_d = '0;
        end else if (state_q == DATA) begin
            if (stuff_c || !raw_bit) begin
                run_d = '0;
            end else begin
                run_d = run_q + RUN_ONE;
            end
        end
    end

    // Run counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    assign stuff_c = 1'b0;
    assign owe     = 1'b0;
`endif

    // Raw bit and end-of-frame detect; an owed stuff extends the frame.
    always_comb begin
        raw_bit  = (state_q == DATA) && !stuff_c && shift_q[WIDTH-1];
        last_bit = 1'b0;
        if (state_q == DATA) begin
            if (stuff_c) begin
                last_bit = (cnt_q == DATA_END);
            end else begin
                last_bit = (cnt_q == DATA_LAST) && !owe;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = SYNC;
            SYNC: if (cnt_q == SYNC_LAST) state_d = DATA;
            DATA: begin
                if (last_bit) begin
                    state_d = (GAP_LEN == 0) ? IDLE : GAP;
                end
            end
            GAP: if (cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifter and phase counter; stuffed cycles freeze both.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                end
            end
            SYNC: begin
                cnt_d = (cnt_q == SYNC_LAST) ? '0 : cnt_q + ONE;
            end
            DATA: begin
                if (last_bit) begin
                    cnt_d = '0;
                end else if (!stuff_c) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + ONE;
                end
            end
            GAP: begin
                cnt_d = (cnt_q == GAP_LAST) ? '0 : cnt_q + ONE;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore-style status outputs decoded from state.
    always_comb begin
        in_ready   = (state_q == IDLE);
        tx_active  = (state_q == SYNC) || (state_q == DATA);
        frame_done = last_bit;
    end

    nrzi_enc_stage u_enc (
        .clock   (clock),
        .reset   (reset),
        .enable  (tx_active),
        .raw_bit (raw_bit),
        .line    (tx_line)
    );

endmodule

// File: tb/tb_nrzi_tx_ctrl.sv
// Scoreboard bench for nrzi_tx_ctrl (WIDTH=16, SYNC_LEN=4, GAP_LEN=2),
// plus a GAP_LEN=0 instance for the back-to-back case.
module tb_nrzi_tx_ctrl;

    localparam int GAPL = 2;
`ifdef NRZI_TX_STUFF_EN
    localparam int FF_LEN = 22;
    localparam bit STUFF = 1'b1;
`else
    localparam int FF_LEN = 20;
    localparam bit STUFF = 1'b0;
`endif

    typedef struct {
        int          hlen;
        logic        hfin;
        int          len;
        logic [31:0] seq;
        logic        fin;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        tx_line;
    logic        tx_active;
    logic        frame_done;

    logic        v0;
    logic [15:0] d0;
    logic        r0;
    logic        l0;
    logic        a0;
    logic        f0;

    int   nvec;
    int   nmis;
    exp_t sb[$];
    logic exp_start;

    nrzi_tx_ctrl #(.WIDTH(16), .SYNC_LEN(4), .GAP_LEN(GAPL)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_line    (tx_line),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    nrzi_tx_ctrl #(.WIDTH(16), .SYNC_LEN(4), .GAP_LEN(0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (v0),
        .in_data    (d0),
        .in_ready   (r0),
        .tx_line    (l0),
        .tx_active  (a0),
        .frame_done (f0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit hit, got %0d req 0", 1);
        $fatal(1);
    end

    function automatic void chk(string nm, int act, int req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0d req %0d", nm, act, req);
        end
    endfunction

    // Reference: preamble of raw 0s, then toggle-on-0, MSB first.
    function automatic void ref_frame(
        input  logic [15:0] w,
        input  logic        start,
        output int          len,
        output logic [31:0] seq,
        output logic        fin
    );
        logic ln;
        int   n;
        int   run;
        ln  = start;
        n   = 0;
        run = 0;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            ln = ~ln;
            seq[n] = ln;
            n++;
        end
        for (int b = 15; b >= 0; b--) begin
            if (!w[b]) ln = ~ln;
            seq[n] = ln;
            n++;
            run = w[b] ? run + 1 : 0;
            if (STUFF && run == 6) begin
                ln = ~ln;
                seq[n] = ln;
                n++;
                run = 0;
            end
        end
        len = n;
        fin = ln;
    endfunction

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic send(
        input logic [15:0] w,
        input int          hl,
        input logic        hf,
        input bit          hold
    );
        exp_t e;
        bit   ok;
        logic s;
        logic ns;
        s = exp_start;
        ns = ~s;
        ref_frame(w, s, e.len, e.seq, e.fin);
        e.hlen = hl;
        e.hfin = hf;
        sb.push_back(e);
        exp_start = e.fin;
        in_valid = 1'b1;
        in_data = w;
        wait_accept(ok);
        chk("accept", int'(ok), 1);
        chk("pre_line", int'(tx_line), int'(s));
        chk("sync_active", int'(tx_active), 1);
        @(posedge clock);
        #1;
        chk("first_toggle", int'(tx_line), int'(ns));
        if (!hold) in_valid = 1'b0;
    endtask

    // Monitor: captures each frame's line trace and checks timing.
    int          cyc;
    int          ncap;
    logic [31:0] cap;
    bit          pa;
    bit          pd;
    bit          pr;
    bit          pacc;
    int          acc_cyc;
    int          done_cyc;

    initial begin
        cyc = 0;
        ncap = 0;
        cap = '0;
        pa = 0;
        pd = 0;
        pr = 1;
        pacc = 0;
        acc_cyc = 0;
        done_cyc = -1;
    end

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (reset) begin
            ncap = 0;
            cap = '0;
            pa = 0;
            pd = 0;
            pr = 1;
            pacc = 0;
            done_cyc = -1;
        end else begin
            if (pacc) chk("ready_drop", int'(in_ready), 0);
            if (in_ready && !pr && done_cyc >= 0)
                chk("gap_len", cyc - done_cyc, GAPL + 1);
            if (pa && ncap < 32) begin
                cap[ncap] = tx_line;
                ncap++;
            end
            if (pd) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL sb_pop: got frame, req none");
                end else begin
                    e = sb.pop_front();
                    chk("frame_len", ncap, e.hlen);
                    chk("model_len", ncap, e.len);
                    chk("line_seq", int'(cap), int'(e.seq));
                    chk("final_line", int'(tx_line), int'(e.hfin));
                    chk("model_fin", int'(tx_line), int'(e.fin));
                    chk("done_lat", done_cyc - acc_cyc, e.hlen);
                end
                ncap = 0;
                cap = '0;
            end
            pd = 0;
            if (frame_done) begin
                chk("done_active", int'(tx_active), 1);
                done_cyc = cyc;
                pd = 1;
            end
            pacc = in_valid && in_ready;
            if (pacc) acc_cyc = cyc;
            pa = tx_active;
            pr = in_ready;
        end
    end

    initial begin
        int cnt;
        bit ok;
        nvec = 0;
        nmis = 0;
        exp_start = 1'b1;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        v0 = 1'b0;
        d0 = '0;
        #1;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_line", int'(tx_line), 1);
        chk("rst_active", int'(tx_active), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst0_ready", int'(r0), 1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        send(16'h0000, 20, 1'b1, 1'b0);
        send(16'hFFFF, FF_LEN, 1'b1, 1'b0);
        send(16'hF163, 20, 1'b0, 1'b0);

        send(16'hCF0C, 20, 1'b0, 1'b1);
        in_data = 16'hDEAD;
        repeat (8) @(posedge clock);
        #1;
        in_data = 16'h8C00;
        send(16'h8C00, 20, 1'b1, 1'b0);

        send(16'hA5A5, 20, 1'b1, 1'b0);
        repeat (9) @(posedge clock);
        #2;
        chk("abort_in_data", int'(tx_active), 1);
        reset = 1'b1;
        sb.delete();
        exp_start = 1'b1;
        #1;
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_line", int'(tx_line), 1);
        chk("abort_active", int'(tx_active), 0);
        chk("abort_done", int'(frame_done), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        send(16'h0F0F, 20, 1'b1, 1'b0);
        repeat (40) @(posedge clock);
        #1;
        chk("sb_empty", sb.size(), 0);

        v0 = 1'b1;
        d0 = 16'h0000;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (f0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("g0_done_seen", int'(ok), 1);
        @(negedge clock);
        chk("g0_ready", int'(r0), 1);
        chk("g0_done_pulse", int'(f0), 0);
        chk("g0_line", int'(l0), 1);
        @(negedge clock);
        chk("g0_restart", int'(a0), 1);
        v0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (a0) cnt++;
            if (f0) break;
            @(negedge clock);
        end
        chk("g0_len", cnt, 20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

endmodule
